// File: rtl/img_pattern_source.sv
// img_pattern_source: image-sensor emulator driving a parallel pixel bus
// (img_dclk / img_d / img_fv / img_lv). Each level change on cmd_frame
// requests one frame of 12-bit pixels that start at PixelInitial and step
// by PixelDelta (mod 2^12) for every pixel.
//
// Optional build macro: IMGPATTERN_JITTER_EN
//   defined     - an 8-bit LFSR adds 0..3 extra periods to every HBlank
//   not defined - blanking is exactly HBlank, fully deterministic timing
//
// FSM states
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | no frame, waiting for a cmd_frame level change
//   ST_ARM     | request accepted, busy=1, waiting for a dclk falling edge
//   ST_LEAD    | fv=1, lv=0 for FVLead periods
//   ST_LINE    | fv=1, lv=1 for ImgWidth periods, img_d = pixel counter
//   ST_HBLANK  | fv=1, lv=0 between lines (HBlank periods, plus jitter)
//   ST_TRAIL   | fv=1, lv=0 for FVTrail periods after the last line
module img_pattern_source #(
  parameter int          ImgWidth     = 2304,
  parameter int          ImgHeight    = 1296,
  parameter int          HBlank       = 16,
  parameter int          FVLead       = 8,
  parameter int          FVTrail      = 8,
  parameter logic [11:0] PixelInitial = 12'hFFF,
  parameter int          PixelDelta   = -1
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        cmd_frame,
  output logic        status_frameDone,
  output logic        status_busy,
  output logic        img_dclk,
  output logic [11:0] img_d,
  output logic        img_fv,
  output logic        img_lv
);

  localparam int ColW         = $clog2(ImgWidth + 1);
  localparam int RowW         = $clog2(ImgHeight + 1);
  localparam int LeadTrailMax = (FVLead > FVTrail) ? FVLead : FVTrail;
  localparam int BlankBase    = (HBlank > LeadTrailMax) ? HBlank : LeadTrailMax;
`ifdef IMGPATTERN_JITTER_EN
  localparam int JitterMax    = 3;
`else
  localparam int JitterMax    = 0;
`endif
  localparam int BlankW       = $clog2(BlankBase + JitterMax + 1);

  localparam logic [11:0]       PixStep    = 12'(PixelDelta);
  localparam logic [BlankW-1:0] LeadLoad   = BlankW'(FVLead - 1);
  localparam logic [BlankW-1:0] TrailLoad  = BlankW'(FVTrail - 1);
  localparam logic [BlankW-1:0] HBlankLoad = BlankW'(HBlank - 1);
  localparam logic [BlankW-1:0] BlankOne   = BlankW'(1);
  localparam logic [ColW-1:0]   ColLoad    = ColW'(ImgWidth - 1);
  localparam logic [ColW-1:0]   ColOne     = ColW'(1);
  localparam logic [RowW-1:0]   RowLoad    = RowW'(ImgHeight - 1);
  localparam logic [RowW-1:0]   RowOne     = RowW'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_LEAD,
    ST_LINE,
    ST_HBLANK,
    ST_TRAIL
  } state_t;

  state_t            state;
  logic              cmd_q;
  logic              req;
  logic              tick;
  logic [11:0]       pix;
  logic [11:0]       pix_next;
  logic [ColW-1:0]   col_cnt;
  logic [RowW-1:0]   row_cnt;
  logic [BlankW-1:0] blank_cnt;
  logic [BlankW-1:0] hblank_load;

  // A level mismatch against the registered copy is a frame request.
  assign req      = cmd_frame != cmd_q;
  // Bus outputs only move on the clk edge that takes img_dclk from 1 to 0.
  assign tick     = img_dclk;
  assign pix_next = pix + PixStep;

`ifdef IMGPATTERN_JITTER_EN
  logic [7:0] lfsr;
  logic       lfsr_fb;

  assign lfsr_fb     = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign hblank_load = HBlankLoad + BlankW'(lfsr[1:0]);

  // Free-running LFSR for x^8+x^6+x^5+x^4+1, sampled on HBlank entry.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) lfsr <= 8'h01;
    else       lfsr <= {lfsr[6:0], lfsr_fb};
  end
`else
  assign hblank_load = HBlankLoad;
`endif

  // Pixel clock: divide clk by two, running from reset.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) img_dclk <= 1'b0;
    else       img_dclk <= ~img_dclk;
  end

  // Frame sequencer with registered bus and status outputs.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state            <= ST_IDLE;
      cmd_q            <= cmd_frame;
      status_frameDone <= 1'b0;
      status_busy      <= 1'b0;
      img_d            <= 12'h000;
      img_fv           <= 1'b0;
      img_lv           <= 1'b0;
      pix              <= 12'h000;
      col_cnt          <= '0;
      row_cnt          <= '0;
      blank_cnt        <= '0;
    end else begin
      cmd_q <= cmd_frame;
      case (state)
        ST_IDLE: begin
          if (req) begin
            state       <= ST_ARM;
            status_busy <= 1'b1;
          end
        end
        ST_ARM: begin
          if (tick) begin
            state     <= ST_LEAD;
            img_fv    <= 1'b1;
            blank_cnt <= LeadLoad;
            pix       <= PixelInitial;
          end
        end
        ST_LEAD: begin
          if (tick) begin
            if (blank_cnt == '0) begin
              state   <= ST_LINE;
              img_lv  <= 1'b1;
              img_d   <= pix;
              col_cnt <= ColLoad;
              row_cnt <= RowLoad;
            end else begin
              blank_cnt <= blank_cnt - BlankOne;
            end
          end
        end
        ST_LINE: begin
          if (tick) begin
            pix <= pix_next;
            if (col_cnt == '0) begin
              img_lv <= 1'b0;
              img_d  <= 12'h000;
              if (row_cnt == '0) begin
                state     <= ST_TRAIL;
                blank_cnt <= TrailLoad;
              end else begin
                state     <= ST_HBLANK;
                blank_cnt <= hblank_load;
                row_cnt   <= row_cnt - RowOne;
              end
            end else begin
              col_cnt <= col_cnt - ColOne;
              img_d   <= pix_next;
            end
          end
        end
        ST_HBLANK: begin
          if (tick) begin
            if (blank_cnt == '0) begin
              state   <= ST_LINE;
              img_lv  <= 1'b1;
              img_d   <= pix;
              col_cnt <= ColLoad;
            end else begin
              blank_cnt <= blank_cnt - BlankOne;
            end
          end
        end
        ST_TRAIL: begin
          if (tick) begin
            if (blank_cnt == '0) begin
              state            <= ST_IDLE;
              img_fv           <= 1'b0;
              status_busy      <= 1'b0;
              status_frameDone <= ~status_frameDone;
            end else begin
              blank_cnt <= blank_cnt - BlankOne;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_img_pattern_source.sv
// tb_img_pattern_source: directed bench for img_pattern_source using a small
// 4x2 frame (main instance) and a 4x1 frame starting at 0x001 (wrap instance).
module tb_img_pattern_source;

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic        cmd_main = 1'b1;
  logic        cmd_wrap = 1'b1;

  logic        m_done, m_busy, m_dclk, m_fv, m_lv;
  logic [11:0] m_d;
  logic        w_done, w_busy, w_dclk, w_fv, w_lv;
  logic [11:0] w_d;

  int tests_run = 0;
  int tests_failed = 0;

  logic [12:0] cap [64];
  int          cap_len;

  // {lv, img_d} per fv-high dclk period, worked out by hand.
  logic [12:0] exp_main [16] = '{
    13'h0000, 13'h0000, 13'h0000,
    13'h1FFF, 13'h1FFE, 13'h1FFD, 13'h1FFC,
    13'h0000, 13'h0000,
    13'h1FFB, 13'h1FFA, 13'h1FF9, 13'h1FF8,
    13'h0000, 13'h0000, 13'h0000
  };
  logic [12:0] exp_wrap [10] = '{
    13'h0000, 13'h0000, 13'h0000,
    13'h1001, 13'h1000, 13'h1FFF, 13'h1FFE,
    13'h0000, 13'h0000, 13'h0000
  };

  img_pattern_source #(
    .ImgWidth(4), .ImgHeight(2), .HBlank(2), .FVLead(3), .FVTrail(3),
    .PixelInitial(12'hFFF), .PixelDelta(-1)
  ) u_main (
    .clk(clk), .rst_(rst_), .cmd_frame(cmd_main),
    .status_frameDone(m_done), .status_busy(m_busy),
    .img_dclk(m_dclk), .img_d(m_d), .img_fv(m_fv), .img_lv(m_lv)
  );

  img_pattern_source #(
    .ImgWidth(4), .ImgHeight(1), .HBlank(2), .FVLead(3), .FVTrail(3),
    .PixelInitial(12'h001), .PixelDelta(-1)
  ) u_wrap (
    .clk(clk), .rst_(rst_), .cmd_frame(cmd_wrap),
    .status_frameDone(w_done), .status_busy(w_busy),
    .img_dclk(w_dclk), .img_d(w_d), .img_fv(w_fv), .img_lv(w_lv)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Record {lv, d} once per dclk period while fv is high, for one frame.
  task automatic capture(input bit sel);
    bit          seen = 1'b0;
    bit          fin = 1'b0;
    logic        dclk, fv, lv, busy;
    logic [11:0] d;
    cap_len = 0;
    for (int i = 0; i < 64; i++) cap[i] = '0;
    for (int i = 0; i < 400 && !fin; i++) begin
      @(negedge clk);
      dclk = sel ? w_dclk : m_dclk;
      fv   = sel ? w_fv   : m_fv;
      lv   = sel ? w_lv   : m_lv;
      busy = sel ? w_busy : m_busy;
      d    = sel ? w_d    : m_d;
      if (dclk) begin
        if (fv) begin
          if (!seen) check($sformatf("busy_at_fv%0d", sel), {31'd0, busy}, 32'd1);
          seen = 1'b1;
          if (cap_len < 64) cap[cap_len] = {lv, d};
          cap_len++;
        end else if (seen) begin
          fin = 1'b1;
        end
      end
    end
    if (!fin) check("capture_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_main(input string tag);
    check({tag, "_fv_len"}, cap_len, 32'd16);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_p%0d", tag, i), {19'd0, cap[i]}, {19'd0, exp_main[i]});
  endtask

  initial begin
    logic d0;

    // Reset held with cmd_frame=1
    repeat (4) @(negedge clk);
    check("rst_dclk", {31'd0, m_dclk}, 32'd0);
    check("rst_d",    {20'd0, m_d},    32'd0);
    check("rst_fv",   {31'd0, m_fv},   32'd0);
    check("rst_lv",   {31'd0, m_lv},   32'd0);
    check("rst_busy", {31'd0, m_busy}, 32'd0);
    check("rst_done", {31'd0, m_done}, 32'd0);
    rst_ = 1'b1;
    repeat (10) @(negedge clk);
    check("no_spurious_fv",   {31'd0, m_fv},   32'd0);
    check("no_spurious_busy", {31'd0, m_busy}, 32'd0);
    d0 = m_dclk;
    @(negedge clk);
    check("dclk_toggle", {31'd0, m_dclk ^ d0}, 32'd1);

    // Frame 1 on the 4x2 instance
    cmd_main = 1'b0;
    capture(1'b0);
    check_main("f1");
    check("f1_done", {31'd0, m_done}, 32'd1);
    check("f1_busy", {31'd0, m_busy}, 32'd0);

    // Pixel wrap through zero
    cmd_wrap = 1'b0;
    capture(1'b1);
    check("wrap_fv_len", cap_len, 32'd10);
    for (int i = 0; i < 10; i++)
      check($sformatf("wrap_p%0d", i), {19'd0, cap[i]}, {19'd0, exp_wrap[i]});
    check("wrap_done", {31'd0, w_done}, 32'd1);

    // Two toggles during a frame are dropped
    cmd_main = 1'b1;
    fork
      capture(1'b0);
      begin
        repeat (10) @(negedge clk);
        cmd_main = 1'b0;
        repeat (8) @(negedge clk);
        cmd_main = 1'b1;
      end
    join
    check_main("f2");
    check("f2_done", {31'd0, m_done}, 32'd0);
    repeat (60) @(negedge clk);
    check("f2_idle_busy", {31'd0, m_busy}, 32'd0);
    check("f2_idle_fv",   {31'd0, m_fv},   32'd0);
    check("f2_idle_done", {31'd0, m_done}, 32'd0);

    // Reset pulsed during line 1
    cmd_main = 1'b0;
    for (int i = 0; i < 100 && !m_lv; i++) @(negedge clk);
    check("lv_seen", {31'd0, m_lv}, 32'd1);
    #3 rst_ = 1'b0;
    #1;
    check("abort_fv",   {31'd0, m_fv},   32'd0);
    check("abort_lv",   {31'd0, m_lv},   32'd0);
    check("abort_d",    {20'd0, m_d},    32'd0);
    check("abort_done", {31'd0, m_done}, 32'd0);
    @(negedge clk);
    rst_ = 1'b1;
    repeat (10) @(negedge clk);
    check("post_abort_fv",   {31'd0, m_fv},   32'd0);
    check("post_abort_busy", {31'd0, m_busy}, 32'd0);

    // Fresh toggle gives a full frame
    cmd_main = 1'b1;
    capture(1'b0);
    check_main("f3");
    check("f3_done", {31'd0, m_done}, 32'd1);
    check("f3_busy", {31'd0, m_busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
